// File: rtl/cfu_mac_engine.sv
// cfu_mac_engine -- int8 dot-product MAC custom function unit.
//
// Accepts one command at a time over a valid/ready handshake, executes it
// after PIPE_STAGES cycles and holds the response until the CPU consumes it.
//   funct7 0 CLEAR      : acc <= 0, response 0
//   funct7 1 SET_OFFSET : offset <= inputs_0[8:0], response = previous offset
//   funct7 2 MAC        : acc += sum_i (A_i + offset) * B_i, response = new acc
//   funct7 3 READ       : response = acc
//   other               : NOP, response 0
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid / cmd_ready           command handshake (ready only in IDLE)
//   cmd_payload_function_id[9:0]    funct7 in [9:3], [2:0] ignored
//   cmd_payload_inputs_0/1[31:0]    operand words A/B, four signed int8 lanes
//   rsp_valid / rsp_ready           response handshake
//   rsp_payload_outputs_0[31:0]     result, ACC_W values sign-extended
//   busy                            high whenever not IDLE
//
// Build option: define CFU_MAC_SATURATE_EN to clamp the accumulator to the
// signed ACC_W range instead of wrapping modulo 2^ACC_W.

// One int8 lane: (sext(a) + offset) * sext(b). The 10x8 product never
// exceeds 17 signed bits, so the top product bit is dropped safely.
module cfu_mac_lane (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [8:0]  offset,
  output logic [16:0] prod
);
  logic signed [9:0]  a_off;
  logic signed [17:0] p_full;

  always_comb begin
    a_off  = 10'($signed(a)) + 10'($signed(offset));
    p_full = 18'(a_off) * 18'($signed(b));
    prod   = p_full[16:0];
  end
endmodule

module cfu_mac_engine #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        busy
);
  localparam int STAGES = PIPE_STAGES - 1;

`ifdef CFU_MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Accumulation is done 34 bits wide so the clamp sees the true sum.
  localparam logic signed [33:0] ACC_MAX = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;
  localparam logic signed [33:0] ACC_MIN = -(34'sd1 <<< (ACC_W - 1));

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [6:0]      f7;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
  } cmd_t;

  state_t              state, state_nxt;
  cmd_t                cmd_q;
  logic [STAGES:0]     vld_pipe;
  logic                accept, commit;
  logic signed [ACC_W-1:0] acc, acc_d, mac_acc;
  logic signed [8:0]   offset, offset_d;
  logic [31:0]         rsp_q, rsp_d;
  logic [3:0][16:0]    prod;
  logic signed [18:0]  lane_sum;
  logic signed [33:0]  nxt_wide;
  logic                unused_fid;

  assign unused_fid = ^cmd_payload_function_id[2:0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        // vld_pipe[STAGES] marks the last EXEC cycle of this command
        if (vld_pipe[STAGES]) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency tracker: bit k set means the command was accepted k+1 edges ago.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q.f7 <= cmd_payload_function_id[9:3];
      cmd_q.a  <= cmd_payload_inputs_0;
      cmd_q.b  <= cmd_payload_inputs_1;
    end
  end

  // ---------------- datapath ----------------
  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < LANES) begin : g_on
      cfu_mac_lane u_lane (
        .a      (cmd_q.a[g]),
        .b      (cmd_q.b[g]),
        .offset (offset),
        .prod   (prod[g])
      );
    end else begin : g_off
      assign prod[g] = '0;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < 4; i++) lane_sum = lane_sum + 19'($signed(prod[i]));
  end

  always_comb begin
    nxt_wide = 34'(acc) + 34'(lane_sum);
    if (SAT_EN && nxt_wide > ACC_MAX)      mac_acc = ACC_MAX[ACC_W-1:0];
    else if (SAT_EN && nxt_wide < ACC_MIN) mac_acc = ACC_MIN[ACC_W-1:0];
    else                                   mac_acc = nxt_wide[ACC_W-1:0];
  end

  always_comb begin
    acc_d    = acc;
    offset_d = offset;
    rsp_d    = '0;
    case (cmd_q.f7)
      7'd0: acc_d = '0;
      7'd1: begin
        offset_d = $signed(cmd_q.a[1][0:0] == 1'b1 ? {cmd_q.a[1][0], cmd_q.a[0]}
                                                   : {1'b0, cmd_q.a[0]});
        rsp_d    = 32'(offset);
      end
      7'd2: begin
        acc_d = mac_acc;
        rsp_d = 32'(mac_acc);
      end
      7'd3: rsp_d = 32'(acc);
      default: ;
    endcase
  end

  // State only changes on the EXEC->RESP edge; a reset before then drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      offset <= '0;
      rsp_q  <= '0;
    end else if (commit) begin
      acc    <= acc_d;
      offset <= offset_d;
      rsp_q  <= rsp_d;
    end
  end

  assign rsp_payload_outputs_0 = rsp_q;

endmodule

// File: tb/tb_cfu_mac_engine.sv
// Self-checking bench for cfu_mac_engine. Three instances cover the default
// configuration, ACC_W=16 with PIPE_STAGES=3, and LANES=2 with PIPE_STAGES=1.
module tb_cfu_mac_engine;
  localparam int N = 3;
  localparam int LN [N] = '{4, 4, 2};
  localparam int PS [N] = '{2, 3, 1};
  localparam int AW [N] = '{32, 16, 32};
`ifdef CFU_MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid [N];
  logic        cmd_ready [N];
  logic [9:0]  fid       [N];
  logic [31:0] in0       [N];
  logic [31:0] in1       [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_out   [N];
  logic        busy      [N];

  int     errors = 0;
  int     checks = 0;
  longint m_acc [N];
  longint m_off [N];

  always #5 clk = ~clk;

  cfu_mac_engine #(.LANES(4), .PIPE_STAGES(2), .ACC_W(32)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_payload_function_id(fid[0]), .cmd_payload_inputs_0(in0[0]),
    .cmd_payload_inputs_1(in1[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_payload_outputs_0(rsp_out[0]), .busy(busy[0]));

  cfu_mac_engine #(.LANES(4), .PIPE_STAGES(3), .ACC_W(16)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_payload_function_id(fid[1]), .cmd_payload_inputs_0(in0[1]),
    .cmd_payload_inputs_1(in1[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_payload_outputs_0(rsp_out[1]), .busy(busy[1]));

  cfu_mac_engine #(.LANES(2), .PIPE_STAGES(1), .ACC_W(32)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_payload_function_id(fid[2]), .cmd_payload_inputs_0(in0[2]),
    .cmd_payload_inputs_1(in1[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_payload_outputs_0(rsp_out[2]), .busy(busy[2]));

  // Reference model: plain integer arithmetic on the command semantics.
  function automatic longint sbyte(input logic [31:0] w, input int i);
    longint v;
    v = (w >> (8 * i)) & 32'hFF;
    if (v > 127) v = v - 256;
    return v;
  endfunction

  function automatic logic [31:0] model_cmd(input int k, input int f7,
                                            input logic [31:0] a, input logic [31:0] b);
    longint s, t, hi, lo, prev, md;
    case (f7)
      0: begin m_acc[k] = 0; return 32'h0; end
      1: begin
        prev = m_off[k];
        t = a & 32'h1FF;
        if (t > 255) t = t - 512;
        m_off[k] = t;
        return prev[31:0];
      end
      2: begin
        s = 0;
        for (int i = 0; i < LN[k]; i++) s = s + (sbyte(a, i) + m_off[k]) * sbyte(b, i);
        t  = m_acc[k] + s;
        md = longint'(1) << AW[k];
        hi = (longint'(1) << (AW[k] - 1)) - 1;
        lo = -hi - 1;
        if (SAT) begin
          if (t > hi) t = hi;
          if (t < lo) t = lo;
        end else begin
          t = t & (md - 1);
          if (t > hi) t = t - md;
        end
        m_acc[k] = t;
        return t[31:0];
      end
      3: return m_acc[k][31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      cmd_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
      fid[k] = '0; in0[k] = '0; in1[k] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin m_acc[k] = 0; m_off[k] = 0; end
  endtask

  // Issue one command on instance k and check handshake, latency and result.
  // noise: toggle the command inputs while busy; stall: cycles to hold
  // rsp_ready low with a competing command presented.
  task automatic issue(input int k, input int f7, input logic [31:0] a,
                       input logic [31:0] b, input bit noise, input int stall,
                       input string tag, output logic [31:0] obs);
    logic [31:0] exp;
    int lat;
    bit got;
    @(negedge clk);
    checks++;
    if (cmd_ready[k] !== 1'b1) begin
      errors++; $display("FAIL %s idle cmd_ready: got %b want 1", tag, cmd_ready[k]);
    end
    fid[k] = {f7[6:0], 3'($urandom_range(0, 7))};
    in0[k] = a; in1[k] = b; cmd_valid[k] = 1'b1;
    exp = model_cmd(k, f7, a, b);
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      if (noise) begin
        cmd_valid[k] = 1'($urandom_range(0, 1));
        fid[k] = 10'($urandom); in0[k] = $urandom; in1[k] = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (rsp_valid[k] === 1'b1) got = 1;
    end
    checks++;
    if (!got || lat != PS[k]) begin
      errors++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, lat, got, PS[k]);
    end
    obs = rsp_out[k];
    checks++;
    if (rsp_out[k] !== exp) begin
      errors++; $display("FAIL %s payload: got %h want %h", tag, rsp_out[k], exp);
    end
    for (int s = 0; s < stall; s++) begin
      cmd_valid[k] = 1'b1; fid[k] = {7'd2, 3'd0}; in0[k] = $urandom; in1[k] = $urandom;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[k] !== 1'b1 || rsp_out[k] !== exp || cmd_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d: valid=%b data=%h ready=%b want 1 %h 0",
                 tag, s, rsp_valid[k], rsp_out[k], cmd_ready[k], exp);
      end
    end
    // Consume, with a command offered on the same edge that must be ignored.
    rsp_ready[k] = 1'b1;
    cmd_valid[k] = noise || (stall > 0);
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0; cmd_valid[k] = 1'b0;
    checks++;
    if (busy[k] !== 1'b0 || rsp_valid[k] !== 1'b0 || cmd_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s release: busy=%b valid=%b ready=%b want 0 0 1",
               tag, busy[k], rsp_valid[k], cmd_ready[k]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cmd_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          rsp_out[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset[%0d]: ready=%b valid=%b busy=%b data=%h want 1 0 0 0",
                 k, cmd_ready[k], rsp_valid[k], busy[k], rsp_out[k]);
      end
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] o;
    for (int k = 0; k < N; k++) begin
      issue(k, 3, $urandom, $urandom, 0, 0, "read_after_reset", o);
      checks++;
      if (o !== 32'h0) begin errors++; $display("FAIL read0[%0d]: got %h want 0", k, o); end
    end
  endtask

  task automatic test_offset_mac();
    logic [31:0] o;
    issue(0, 1, 32'd128, $urandom, 0, 0, "set_offset128", o);
    issue(0, 2, 32'h0, 32'h01010101, 0, 0, "mac_offset", o);
    checks++;
    if (o !== 32'd512) begin errors++; $display("FAIL mac_offset const: got %h want 200", o); end
    issue(0, 3, $urandom, $urandom, 0, 0, "read512", o);
    checks++;
    if (o !== 32'd512) begin errors++; $display("FAIL read512 const: got %h want 200", o); end
  endtask

  task automatic test_stall();
    logic [31:0] o;
    issue(0, 2, $urandom, $urandom, 0, 5, "stall_mac", o);
    issue(0, 3, 32'h0, 32'h0, 0, 0, "stall_read", o);
  endtask

  task automatic test_saturate();
    logic [31:0] o;
    issue(1, 0, 32'h0, 32'h0, 0, 0, "sat_clear", o);
    issue(1, 1, 32'd127, 32'h0, 0, 0, "sat_offset", o);
    issue(1, 2, 32'h7F7F7F7F, 32'h80808080, 0, 0, "sat_mac", o);
    checks++;
    if (o !== (SAT ? 32'hFFFF8000 : 32'h00000400)) begin
      errors++; $display("FAIL sat_mac const: got %h want %h", o, SAT ? 32'hFFFF8000 : 32'h400);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] o;
    issue(2, 0, 32'h0, 32'h0, 0, 0, "ln_clear", o);
    issue(2, 1, 32'h0, 32'h0, 0, 0, "ln_offset", o);
    issue(2, 2, 32'h01010101, 32'h01010101, 0, 0, "ln_mac", o);
    checks++;
    if (o !== 32'd2) begin errors++; $display("FAIL ln_mac const: got %h want 2", o); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] o;
    bit seen;
    @(negedge clk);
    fid[0] = {7'd2, 3'd0}; in0[0] = 32'h05050505; in1[0] = 32'h03030303; cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin m_acc[k] = 0; m_off[k] = 0; end
    seen = 0;
    for (int c = 0; c < PS[0] + 3; c++) begin
      if (rsp_valid[0] !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort: rsp_valid seen=1 want 0"); end
    issue(0, 3, 32'h0, 32'h0, 0, 0, "abort_read", o);
    checks++;
    if (o !== 32'h0) begin errors++; $display("FAIL abort_read const: got %h want 0", o); end
  endtask

  task automatic test_random();
    logic [31:0] o;
    int r, f7;
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 25; n++) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      f7 = 2;
        else if (r == 6) f7 = 0;
        else if (r == 7) f7 = 1;
        else if (r == 8) f7 = 3;
        else             f7 = $urandom_range(4, 127);
        issue(k, f7, $urandom, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), "random", o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_offset_mac();
    test_stall();
    test_saturate();
    test_lanes();
    test_reset_abort();
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cfu_mac_engine.md
CFU_MAC_ENGINE -- requirements
Module: cfu_mac_engine

Interface
REQ-001 SHALL have parameter LANES, default 4: number of active int8 lanes per 32-bit operand word (legal 1..4).
REQ-002 SHALL have parameter PIPE_STAGES, default 2: command latency in cycles (legal 1..4).
REQ-003 SHALL have parameter ACC_W, default 32: accumulator width in bits (legal 16..32).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request from CPU.
REQ-007 SHALL have port cmd_ready  output  1  engine can accept a command.
REQ-008 SHALL have port cmd_payload_function_id  input  10  command code; funct7 = bits[9:3]; bits[2:0] ignored.
REQ-009 SHALL have port cmd_payload_inputs_0  input  32  operand A, lane i = bits[8i+7:8i], signed.
REQ-010 SHALL have port cmd_payload_inputs_1  input  32  operand B, same lane layout, signed.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  CPU consumes response.
REQ-013 SHALL have port rsp_payload_outputs_0  output  32  result; ACC_W values sign-extended to 32 bits.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready high only in IDLE.
REQ-016 SHALL accept a command on the edge where cmd_valid && cmd_ready, latching funct7 and both operands, and move IDLE -> EXEC.
REQ-017 SHALL count PIPE_STAGES-1 cycles in EXEC, then enter RESP; command accepted at edge N gives rsp_valid high after edge N+PIPE_STAGES; PIPE_STAGES=1 enters RESP directly.
REQ-018 SHALL hold rsp_valid and rsp_payload_outputs_0 stable in RESP until rsp_ready is high at a clock edge, then return to IDLE; no command accepted in that same cycle.
REQ-019 SHALL ignore cmd_valid outside IDLE; operands changing after acceptance have no effect.
REQ-020 SHALL decode funct7 0 CLEAR: acc <= 0; response 0.
REQ-021 SHALL decode funct7 1 SET_OFFSET: offset <= inputs_0[8:0] (signed 9-bit); response previous offset sign-extended.
REQ-022 SHALL decode funct7 2 MAC: acc <= acc + sum over i<LANES of (sext(A_i)+offset)*sext(B_i); response updated acc.
REQ-023 SHALL decode funct7 3 READ: response acc, no state change.
REQ-024 SHALL treat any other funct7 as NOP: response 32'h0, no state change, same latency.
REQ-025 SHALL ignore lanes >= LANES (bytes contribute zero).
REQ-026 SHALL compute lane products at 17-bit signed, lane sum at 19-bit signed, sign-extended to ACC_W before accumulation.
REQ-027 SHALL commit acc/offset updates at the EXEC->RESP transition only.

Reset
REQ-028 SHALL on reset drive state IDLE, acc 0, offset 0, rsp_valid 0, rsp_payload_outputs_0 0, busy 0, cmd_ready 1 from the next cycle.
REQ-029 SHALL on reset during EXEC or RESP abort the command, suppress its response, and not commit its update.

Configuration
REQ-030 SHALL, with CFU_MAC_SATURATE_EN defined, clamp accumulation to signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-031 SHALL, without CFU_MAC_SATURATE_EN, wrap accumulation modulo 2^ACC_W (two's complement).

Verification
REQ-032 SHALL cover: reset, then READ -> rsp_valid exactly PIPE_STAGES cycles after accept, payload 0.
REQ-033 SHALL cover: SET_OFFSET 128, MAC A=0x00000000 B=0x01010101 (LANES=4) -> response 512; READ -> 512.
REQ-034 SHALL cover: rsp_ready held low 5 cycles with cmd_valid high -> rsp_valid and payload stable, cmd_ready 0, no second command taken.
REQ-035 SHALL cover: ACC_W=16, offset 127, MAC A=0x7F7F7F7F B=0x80808080 -> response 0xFFFF8000 with CFU_MAC_SATURATE_EN, 0x00000400 without.
REQ-036 SHALL cover: LANES=2, offset 0, MAC A=0x01010101 B=0x01010101 -> response 2.
REQ-037 SHALL cover: MAC accepted, reset asserted 1 cycle later -> no rsp_valid, READ afterwards returns 0.
